// File: rtl/uart_pkg.sv
// Shared UART definitions: receive FSM states, data-width encoding and the
// helper that turns that encoding into a bit count.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } rx_state_e;

    localparam logic [1:0] DBITS_5 = 2'b00;
    localparam logic [1:0] DBITS_6 = 2'b01;
    localparam logic [1:0] DBITS_7 = 2'b10;
    localparam logic [1:0] DBITS_8 = 2'b11;

    function automatic logic [3:0] data_bits(input logic [1:0] enc);
        return 4'd5 + {2'b00, enc};
    endfunction

endpackage

// File: rtl/uart_sync.sv
// Multi-flop synchronizer for an asynchronous level; resets to 1 so an
// idle-high line does not look like a start bit after reset.
module uart_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] ff;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ff <= '1;
        end else begin
            ff[0] <= d;
            for (int i = 1; i < STAGES; i++) begin
                ff[i] <= ff[i-1];
            end
        end
    end

    assign q = ff[STAGES-1];

endmodule

// File: rtl/uart_rx_frame.sv
// 16x-oversampled UART receive engine: start validation, 5-8 data bits,
// optional parity, 1 or 2 stop bits, with pending/overrun tracking and rts_n.
module uart_rx_frame
    import uart_pkg::*;
#(
    parameter int OVERSAMPLE  = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        rx_tick,
    input  logic [1:0]  data_bit_num_i,
    input  logic        parity_en_i,
    input  logic        parity_type_i,
    input  logic        stop_bit_num_i,
    input  logic        rx,
    input  logic        rx_ack_i,
    output logic        rx_done_o,
    output logic [31:0] rx_data_o,
    output logic        parity_err_o,
    output logic        frame_err_o,
    output logic        overrun_o,
    output logic        rts_n
);

    localparam int TW = $clog2(OVERSAMPLE);
    localparam logic [TW-1:0] HALF = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] LAST = TW'(OVERSAMPLE - 1);

    rx_state_e   state, state_d;
    logic        rxs;
    logic [TW-1:0] tick_cnt;
    logic [2:0]  bit_cnt;
    logic [7:0]  shreg;
    logic [1:0]  cfg_dbits;
    logic        cfg_pen, cfg_ptype, cfg_stop2;
    logic        par_bit, ferr_acc, pending;
    logic        mid, start_ok, complete;
    logic [2:0]  last_bit;

    uart_sync #(.STAGES(SYNC_STAGES)) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (rx),
        .q     (rxs)
    );

    // Mid-bit sample point: the tick on which the counter wraps.
    assign mid      = rx_tick && (tick_cnt == LAST);
    assign last_bit = 3'(data_bits(cfg_dbits) - 4'd1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_d;
    end

    always_comb begin
        state_d  = state;
        start_ok = 1'b0;
        complete = 1'b0;
        case (state)
            IDLE:    if (rx_tick && !rxs) state_d = START;
            START: begin
                if (rx_tick && tick_cnt == HALF) begin
                    if (rxs) begin
                        state_d = IDLE;
                    end else begin
                        state_d  = DATA;
                        start_ok = 1'b1;
                    end
                end
            end
            DATA:    if (mid && bit_cnt == last_bit) state_d = cfg_pen ? PARITY : STOP;
            PARITY:  if (mid) state_d = STOP;
            STOP: begin
                if (mid && bit_cnt[0] == cfg_stop2) begin
                    state_d  = IDLE;
                    complete = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Counters, shifter and latched frame configuration.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tick_cnt  <= '0;
            bit_cnt   <= '0;
            shreg     <= '0;
            cfg_dbits <= DBITS_8;
            cfg_pen   <= 1'b0;
            cfg_ptype <= 1'b0;
            cfg_stop2 <= 1'b0;
            par_bit   <= 1'b0;
            ferr_acc  <= 1'b0;
        end else if (rx_tick) begin
            case (state)
                IDLE: tick_cnt <= '0;
                START: begin
                    if (start_ok) begin
                        tick_cnt  <= '0;
                        bit_cnt   <= '0;
                        shreg     <= '0;
                        ferr_acc  <= 1'b0;
                        par_bit   <= 1'b0;
                        cfg_dbits <= data_bit_num_i;
                        cfg_pen   <= parity_en_i;
                        cfg_ptype <= parity_type_i;
                        cfg_stop2 <= stop_bit_num_i;
                    end else begin
                        tick_cnt <= tick_cnt + 1'b1;
                    end
                end
                default: begin
                    tick_cnt <= mid ? '0 : tick_cnt + 1'b1;
                    if (mid) begin
                        case (state)
                            DATA: begin
                                shreg[bit_cnt] <= rxs;
                                bit_cnt <= (bit_cnt == last_bit) ? 3'd0 : bit_cnt + 3'd1;
                            end
                            PARITY: par_bit <= rxs;
                            STOP: begin
                                if (!rxs) ferr_acc <= 1'b1;
                                bit_cnt <= bit_cnt + 3'd1;
                            end
                            default: ;
                        endcase
                    end
                end
            endcase
        end
    end

    // Frame delivery; an ack coinciding with completion retires the old word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_done_o    <= 1'b0;
            rx_data_o    <= '0;
            parity_err_o <= 1'b0;
            frame_err_o  <= 1'b0;
            overrun_o    <= 1'b0;
            pending      <= 1'b0;
            rts_n        <= 1'b1;
        end else begin
            rx_done_o <= complete;
            rts_n     <= pending;
            if (complete) begin
                rx_data_o    <= {24'd0, shreg};
                parity_err_o <= cfg_pen & ((^shreg ^ par_bit) != cfg_ptype);
                frame_err_o  <= ferr_acc | ~rxs;
                pending      <= 1'b1;
                overrun_o    <= rx_ack_i ? 1'b0 : (overrun_o | pending);
            end else if (rx_ack_i) begin
                pending   <= 1'b0;
                overrun_o <= 1'b0;
            end
        end
    end

endmodule

// File: doc/uart_rx_frame.md
# uart_rx_frame

Serial receive engine of the APB-UART: a 16x-oversampled receiver that turns the `rx` line into parallel words. It supports 5–8 data bits, optional even/odd parity and 1 or 2 stop bits, and it drives `rts_n` flow control. It is the receive-direction counterpart of the transmitter inside `uart_core`. It shares the transmitter's configuration inputs, and its outputs go to the register block.

## Interface
- `OVERSAMPLE`, default 16: `rx_tick` strobes per bit period. Must be an even value of at least 8.
- `SYNC_STAGES`, default 2: flip-flop depth of the `rx` synchronizer.
- `clk` in 1: the single clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `rx_tick` in 1: one-`clk` strobe at `OVERSAMPLE` × baud.
- `data_bit_num_i` in 2: 00=5, 01=6, 10=7, 11=8 data bits.
- `parity_en_i` in 1: 1 = a parity bit follows the data.
- `parity_type_i` in 1: 0 = even, 1 = odd.
- `stop_bit_num_i` in 1: 0 = one stop bit, 1 = two stop bits.
- `rx` in 1: asynchronous serial input; idles high.
- `rx_ack_i` in 1: one-cycle pulse from the register block meaning "word consumed".
- `rx_done_o` out 1: one-cycle pulse when a frame completes.
- `rx_data_o` out 32: last received word, LSB-aligned and zero-extended.
- `parity_err_o` out 1: parity status of the last frame.
- `frame_err_o` out 1: a stop bit of the last frame sampled 0.
- `overrun_o` out 1: sticky; a frame completed while the previous word was unread.
- `rts_n` out 1: 0 = ready to accept a frame, 1 = hold off the sender.

## Operation
- `rx` passes through the `SYNC_STAGES` flip-flop synchronizer; all decisions use the synchronized value `rxs`.
- Configuration inputs are latched at start-bit validation and held for the whole frame.
- FSM states: IDLE, START, DATA, PARITY, STOP.
- Counters: a tick counter (`$clog2(OVERSAMPLE)` bits) and a bit counter (3 bits). Both advance only on `rx_tick`.
- **IDLE**: on `rxs==0`, clear the tick counter and go to START.
- **START**: at tick `OVERSAMPLE/2-1`, sample `rxs`.
  - If `rxs==1`, treat it as a glitch and return to IDLE with no outputs changed.
  - Otherwise clear the tick counter and go to DATA.
- **DATA**: sample at each tick-counter wrap (`OVERSAMPLE-1`), i.e. mid-bit. Shift the sample in LSB first.
  - After N bits, go to PARITY if `parity_en` is set, else STOP.
- **PARITY**: sample one bit.
  - Error when the XOR of the data bits and the parity bit ≠ `parity_type` (even: total number of ones is even).
- **STOP**: sample 1 or 2 stop bits. Any stop bit sampled 0 sets the frame error.
  - After the last stop sample, complete the frame and go to IDLE. The line is not required to stay high beyond mid-stop.
- **Frame completion**, in one `clk` edge:
  - `rx_data_o` ← data zero-extended to 32 bits; bits above N are 0.
  - `parity_err_o` and `frame_err_o` are updated (parity error is 0 when parity is disabled).
  - `rx_done_o` pulses.
  - The pending flag is set.
  - The frame is delivered even when it carries errors.
- **Pending and ready**:
  - `rx_ack_i` clears the pending flag and `overrun_o`.
  - `rts_n` = pending, as a registered signal.
- **Overrun**: frame completion while the pending flag is set sets `overrun_o`; the data is overwritten.
  - If `rx_ack_i` arrives in the same cycle as completion, the ack applies to the old word. Pending stays 1 and `overrun_o` is not set.
- Reception continues while `rts_n==1`; `rts_n` is advisory to the far end.

## Timing
- Reset values:
  - `rx_data_o` = 0, `rx_done_o` = 0, all error flags = 0, `rts_n` = 1.
  - Synchronizer flip-flops = 1; FSM in IDLE.
  - `rts_n` drops to 0 on the first `clk` edge after reset is released.
- Reset asserted mid-frame aborts the frame immediately: no `rx_done_o`, and the data is discarded.
- `rx_done_o` is exactly one `clk` wide, in the cycle after the `rx_tick` that samples the last stop bit.
- Edge detection lags `rx` by `SYNC_STAGES` clocks plus up to one tick.
- `rx_tick` must never be asserted on consecutive clocks; if it is, behaviour is unspecified.
- All outputs are registered; there are no combinational paths from input to output.
- `rts_n` rises on the `clk` edge after `rx_done_o` and falls on the edge after `rx_ack_i`.

## Structure
- `uart_pkg` holds:
  - the state enum `rx_state_e`;
  - the data-bit encoding constants;
  - the function `data_bits(logic [1:0])` returning 5..8, shared with `uart_tx`.
- Sub-module `uart_sync`: a parameterized synchronizer with reset value 1.
- The FSM, counters and shifter stay in `uart_rx_frame`.

## Test plan
- **8N1**, byte 0xA5: `rx_data_o` = 0x000000A5; one `rx_done_o` pulse; no errors; `rts_n` = 1 until `rx_ack_i`.
- **7E1**, data 0x41 sent with parity bit 1 (wrong): `rx_data_o` = 0x41 and `parity_err_o` = 1. Sending it again with parity 0 gives `parity_err_o` = 0.
- **5O2**, data 0x1F with the second stop bit driven 0: `frame_err_o` = 1 and `rx_data_o` = 0x1F.
- **Glitch**: `rx` low for 4 ticks, then high: FSM returns to IDLE; no `rx_done_o`; outputs unchanged.
- **Overrun**: receive 0x11, then 0x22 with no ack: `overrun_o` = 1 and `rx_data_o` = 0x22. Then pulse `rx_ack_i` in the same cycle as completion of 0x33: `overrun_o` stays 0 and pending stays 1.
- **Reset mid-frame**, after 3 data bits: all outputs return to their reset values. The next full 0x5A frame is received correctly.
